// File: rtl/sja1000_slv_pkg.sv
// Shared definitions for the SJA1000-style bus slave: FSM state encoding,
// the packed layout of one synchronized bus sample, and the parameter defaults.
package sja1000_slv_pkg;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 64;
  localparam int SYNC_WIDTH         = 12;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_WRITE    = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_RD_DRIVE = 3'd4
  } slv_state_t;

  // One bus sample, in the same bit order as it travels through the synchronizer.
  typedef struct packed {
    logic       ale;
    logic       csn;
    logic       rdn;
    logic       wrn;
    logic [7:0] ad;
  } bus_sample_t;

  // States in which the bus master holds a strobe and the watchdog is running.
  function automatic logic is_timed_state(slv_state_t s);
    return (s == ST_WRITE) || (s == ST_RD_WAIT) || (s == ST_RD_DRIVE);
  endfunction

endpackage

// File: rtl/sja1000_sync_module.sv
// Multi-flop synchronizer, WIDTH bits wide and DEPTH stages deep.
// Resets to all ones so that the active-low bus strobes come out of reset
// at their idle level.
module sja1000_sync_module #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [DEPTH*WIDTH-1:0] chain;

  // Shift the whole bus one stage per clock; every bit sees the same latency.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      chain <= '1;
    end else begin
      chain <= {chain[(DEPTH-1)*WIDTH-1:0], d};
    end
  end

  assign q = chain[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/sja1000_bus_slave_module.sv
// SJA1000-style multiplexed address/data bus slave.
// Converts the asynchronous ALE/CSn/RDn/WRn/AD bus into single-cycle register
// write strobes and read requests in the sys_clk domain.
// Optional watchdog: define SJA1000_SLV_TIMEOUT_EN to abort any WRITE, RD_WAIT or
// RD_DRIVE phase that lasts TIMEOUT_CYCLES clocks; otherwise timeout_err_o is 0.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | nothing latched yet (after reset or watchdog abort)
// ADDR        | address latched, waiting for a CSn+RDn or CSn+WRn strobe
// WRITE       | master write strobe active, sampling data every cycle
// RD_WAIT     | read request issued, waiting for reg_rd_ack_i
// RD_DRIVE    | driving the registered read data onto bus_ad_io
module sja1000_bus_slave_module
  import sja1000_slv_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       bus_ale_i,
  input  logic       bus_csn_i,
  input  logic       bus_rdn_i,
  input  logic       bus_wrn_i,
  inout  wire  [7:0] bus_ad_io,
  output logic       bus_dir_o,
  output logic [7:0] reg_addr_o,
  output logic       reg_wr_en_o,
  output logic [7:0] reg_wr_data_o,
  output logic       reg_rd_req_o,
  input  logic [7:0] reg_rd_data_i,
  input  logic       reg_rd_ack_i,
  output logic       timeout_err_o
);

  // Reject illegal parameter combinations at elaboration time.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("sja1000_bus_slave_module: SYNC_STAGES must be 2..3 and TIMEOUT_CYCLES >= 2");
  end

  bus_sample_t             raw;
  logic [SYNC_WIDTH-1:0]   syn_vec;
  bus_sample_t             syn;
  slv_state_t              state;
  slv_state_t              state_next;
  logic                    ale_prev;
  logic                    ale_fall;
  logic                    addr_load;
  logic                    wr_commit;
  logic                    rd_launch;
  logic                    rd_accept;
  logic                    tmo_hit;
  logic [7:0]              rd_data_q;

  assign raw = {bus_ale_i, bus_csn_i, bus_rdn_i, bus_wrn_i, bus_ad_io};

  sja1000_sync_module #(
    .WIDTH (SYNC_WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .d       (raw),
    .q       (syn_vec)
  );

  assign syn      = syn_vec;
  assign ale_fall = ale_prev & ~syn.ale;

`ifdef SJA1000_SLV_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires in the last permitted cycle so the abort lands exactly on the limit.
  assign tmo_hit = is_timed_state(state) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on every state change, counts only while a strobe phase lasts.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tmo_cnt <= '0;
    end else if (state_next != state) begin
      tmo_cnt <= '0;
    end else if (is_timed_state(state)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Registered single-cycle abort pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      timeout_err_o <= 1'b0;
    end else begin
      timeout_err_o <= tmo_hit;
    end
  end
`else
  assign tmo_hit       = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; the watchdog wins over everything, then a new address.
  always_comb begin
    state_next = state;
    addr_load  = 1'b0;
    wr_commit  = 1'b0;
    rd_launch  = 1'b0;
    rd_accept  = 1'b0;
    if (tmo_hit) begin
      state_next = ST_IDLE;
    end else if (ale_fall && (state != ST_RD_DRIVE)) begin
      state_next = ST_ADDR;
      addr_load  = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_IDLE;
        end
        ST_ADDR: begin
          // RDn and WRn low together is a bus error and is simply ignored.
          if (!syn.csn && !syn.wrn && syn.rdn) begin
            state_next = ST_WRITE;
          end else if (!syn.csn && !syn.rdn && syn.wrn) begin
            state_next = ST_RD_WAIT;
            rd_launch  = 1'b1;
          end
        end
        ST_WRITE: begin
          if (syn.csn || syn.wrn) begin
            state_next = ST_ADDR;
            wr_commit  = 1'b1;
          end
        end
        ST_RD_WAIT: begin
          // A master that gives up in the same cycle as the ack wins: never drive.
          if (syn.csn || syn.rdn) begin
            state_next = ST_ADDR;
          end else if (reg_rd_ack_i) begin
            state_next = ST_RD_DRIVE;
            rd_accept  = 1'b1;
          end
        end
        ST_RD_DRIVE: begin
          if (syn.csn || syn.rdn) begin
            state_next = ST_ADDR;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded from the current state only, so reset releases the bus at once.
  always_comb begin
    bus_dir_o = (state == ST_RD_DRIVE);
  end

  assign bus_ad_io = bus_dir_o ? rd_data_q : 8'hzz;

  // Address/data capture and the single-cycle register-side strobes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ale_prev      <= 1'b1;
      reg_addr_o    <= 8'h00;
      reg_wr_data_o <= 8'h00;
      reg_wr_en_o   <= 1'b0;
      reg_rd_req_o  <= 1'b0;
      rd_data_q     <= 8'h00;
    end else begin
      ale_prev     <= syn.ale;
      reg_wr_en_o  <= wr_commit;
      reg_rd_req_o <= rd_launch;
      if (addr_load) begin
        reg_addr_o <= syn.ad;
      end
      // Sample on entry and on every cycle the write strobe is still held.
      if (state_next == ST_WRITE) begin
        reg_wr_data_o <= syn.ad;
      end
      if (rd_accept) begin
        rd_data_q <= reg_rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_sja1000_bus_slave_module.sv
// Randomized bench for sja1000_bus_slave_module: a bus-master driver issues
// whole transactions (write, read, aborted read, RD/WR conflict); expectations
// come from a transaction-level model of what the register side must see.
module tb_sja1000_bus_slave_module;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       ale, csn, rdn, wrn;
  logic [7:0] ad_drv;
  logic       ad_en;
  wire  [7:0] bus_ad;
  logic       bus_dir;
  logic [7:0] reg_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_ack;
  logic       tmo_err;

  assign bus_ad = ad_en ? ad_drv : 8'hzz;

  sja1000_bus_slave_module #(
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .bus_ale_i     (ale),
    .bus_csn_i     (csn),
    .bus_rdn_i     (rdn),
    .bus_wrn_i     (wrn),
    .bus_ad_io     (bus_ad),
    .bus_dir_o     (bus_dir),
    .reg_addr_o    (reg_addr),
    .reg_wr_en_o   (wr_en),
    .reg_wr_data_o (wr_data),
    .reg_rd_req_o  (rd_req),
    .reg_rd_data_i (rd_data),
    .reg_rd_ack_i  (rd_ack),
    .timeout_err_o (tmo_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Register-side monitor, sampled on the falling edge.
  int         mon_wr, mon_req, mon_tmo;
  logic       mon_dir;
  logic [7:0] mon_wr_addr, mon_wr_data;

  always @(negedge sys_clk) begin
    if (wr_en) begin
      mon_wr++;
      mon_wr_addr = reg_addr;
      mon_wr_data = wr_data;
    end
    if (rd_req) mon_req++;
    if (tmo_err) mon_tmo++;
    if (bus_dir) mon_dir = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic clear_mon();
    mon_wr  = 0;
    mon_req = 0;
    mon_dir = 1'b0;
  endtask

  task automatic addr_phase(input logic [7:0] addr);
    ad_en  = 1'b1;
    ad_drv = addr;
    ale    = 1'b1;
    cyc(2);
    ale = 1'b0;
    cyc(SYNC + 2);
    chk("addr_latch", reg_addr, addr);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    clear_mon();
    addr_phase(addr);
    ad_drv = data;
    csn    = 1'b0;
    wrn    = 1'b0;
    cyc(8);
    wrn = 1'b1;
    csn = 1'b1;
    cyc(SYNC + 3);
    ad_en = 1'b0;
    chk("wr_pulses", mon_wr, 1);
    chk("wr_addr", mon_wr_addr, addr);
    chk("wr_data", mon_wr_data, data);
    chk("wr_no_req", mon_req, 0);
    chk("wr_no_drive", mon_dir, 0);
    chk("wr_addr_hold", reg_addr, addr);
  endtask

  // mode 0: normal read, 1: master aborts before ack, 2: reset while driving
  task automatic do_read(input logic [7:0] addr, input logic [7:0] data,
                         input int dly, input int mode);
    int  waited;
    int  rel;
    clear_mon();
    addr_phase(addr);
    ad_en = 1'b0;
    csn   = 1'b0;
    rdn   = 1'b0;
    waited = 0;
    while (!rd_req && waited < 10) begin
      cyc(1);
      waited++;
    end
    chk("rd_req_seen", rd_req, 1);
    if (mode == 1) begin
      cyc(1);
      csn = 1'b1;
      rdn = 1'b1;
      cyc(SYNC + 4);
      chk("abort_req_once", mon_req, 1);
      chk("abort_no_drive", mon_dir, 0);
      chk("abort_no_wr", mon_wr, 0);
      return;
    end
    cyc(dly);
    rd_ack  = 1'b1;
    rd_data = data;
    cyc(1);
    rd_ack  = 1'b0;
    rd_data = ~data;
    waited  = 0;
    while (!bus_dir && waited < 6) begin
      cyc(1);
      waited++;
    end
    chk("rd_dir_on", bus_dir, 1);
    chk("rd_bus_data", bus_ad, data);
    if (mode == 2) begin
      #2 sys_rst = 1'b1;
      #1;
      chk("rst_dir_async", bus_dir, 0);
      chk("rst_addr", reg_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_strobes", {wr_en, rd_req, tmo_err}, 0);
      ale = 1'b1;
      csn = 1'b1;
      rdn = 1'b1;
      cyc(2);
      sys_rst = 1'b0;
      cyc(SYNC + 2);
      chk("post_rst_dir", bus_dir, 0);
      return;
    end
    cyc(1);
    rdn = 1'b1;
    csn = 1'b1;
    rel = 0;
    while (bus_dir && rel < 8) begin
      cyc(1);
      rel++;
    end
    chk("rd_release_in_time", (rel <= SYNC + 1) && !bus_dir, 1);
    cyc(2);
    chk("rd_req_once", mon_req, 1);
    chk("rd_no_wr", mon_wr, 0);
  endtask

  task automatic do_conflict(input logic [7:0] addr);
    clear_mon();
    addr_phase(addr);
    ad_en  = 1'b0;
    rd_ack = 1'b1;
    cyc(1);
    rd_ack = 1'b0;
    csn = 1'b0;
    rdn = 1'b0;
    wrn = 1'b0;
    cyc(6);
    csn = 1'b1;
    rdn = 1'b1;
    wrn = 1'b1;
    cyc(SYNC + 2);
    chk("cfl_no_wr", mon_wr, 0);
    chk("cfl_no_req", mon_req, 0);
    chk("cfl_no_drive", mon_dir, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int kind;
    logic [7:0] a, d;
    mon_tmo = 0;
    clear_mon();
    sys_rst = 1'b1;
    ale = 1'b1;
    csn = 1'b1;
    rdn = 1'b1;
    wrn = 1'b1;
    ad_en  = 1'b0;
    ad_drv = 8'h00;
    rd_ack = 1'b0;
    rd_data = 8'h00;
    cyc(3);
    chk("rst_dir", bus_dir, 0);
    chk("rst_addr0", reg_addr, 0);
    chk("rst_wr_data0", wr_data, 0);
    chk("rst_strobes0", {wr_en, rd_req, tmo_err}, 0);
    sys_rst = 1'b0;
    cyc(SYNC + 3);
    chk("idle_dir", bus_dir, 0);
    chk("idle_addr", reg_addr, 0);

    do_write(8'h12, 8'hA5);
    do_read(8'h04, 8'h3C, 2, 0);
    do_read(8'h21, 8'h00, 0, 1);
    do_conflict(8'h33);

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      a    = 8'($urandom);
      d    = 8'($urandom);
      case (kind)
        0: do_write(a, d);
        1: do_read(a, d, $urandom_range(0, 3), 0);
        2: do_read(a, d, 0, 1);
        default: do_conflict(a);
      endcase
    end

    do_read(8'h55, 8'h99, 1, 2);

`ifdef SJA1000_SLV_TIMEOUT_EN
    begin
      int lat;
      clear_mon();
      mon_tmo = 0;
      addr_phase(8'h77);
      ad_drv = 8'h5A;
      csn = 1'b0;
      wrn = 1'b0;
      lat = 0;
      while (!tmo_err && lat < TMO + 20) begin
        cyc(1);
        lat++;
      end
      chk("tmo_pulse", tmo_err, 1);
      chk("tmo_latency", (lat >= TMO) && (lat <= TMO + SYNC + 2), 1);
      cyc(4);
      wrn = 1'b1;
      csn = 1'b1;
      cyc(SYNC + 3);
      chk("tmo_no_wr", mon_wr, 0);
      chk("tmo_one_pulse", mon_tmo, 1);
      csn = 1'b0;
      rdn = 1'b0;
      cyc(SYNC + 4);
      chk("tmo_idle_no_req", mon_req, 0);
      csn = 1'b1;
      rdn = 1'b1;
      ad_en = 1'b0;
      cyc(SYNC + 2);
    end
`else
    chk("tmo_tied_low", mon_tmo, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sja1000_bus_slave_module.md
SJA1000_BUS_SLAVE_MODULE -- requirements
Module: sja1000_bus_slave_module

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on all bus inputs, legal range 2-3.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit in sys_clk cycles.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 sys_clk  in  1  system clock; all logic on its rising edge.
REQ-005 sys_rst  in  1  asynchronous active-high reset.
REQ-006 bus_ale_i  in  1  address latch enable; address is captured on its falling edge.
REQ-007 bus_csn_i / bus_rdn_i / bus_wrn_i  in  1 each  active-low chip select, read strobe and write strobe.
REQ-008 bus_ad_io  inout  8  multiplexed address/data bus.
REQ-009 bus_dir_o  out  1  transceiver direction; 1 = this block drives bus_ad_io.
REQ-010 reg_addr_o  out  8  latched register address.
REQ-011 reg_wr_en_o / reg_wr_data_o  out  1 / 8  single-cycle write strobe and its data.
REQ-012 reg_rd_req_o  out  1  single-cycle read request.
REQ-013 reg_rd_data_i / reg_rd_ack_i  in  8 / 1  read data, valid in the cycle ack is high.
REQ-014 timeout_err_o  out  1  single-cycle watchdog abort pulse.

Function
REQ-015 SHALL pass ALE, CSn, RDn, WRn and AD through SYNC_STAGES flops, so all edges are detected at equal latency.
REQ-016 FSM states SHALL be IDLE, ADDR, WRITE, RD_WAIT and RD_DRIVE.
REQ-017 On synced ALE falling edge, in any state except RD_DRIVE: latch synced AD into reg_addr_o and enter ADDR.
REQ-018 ADDR to WRITE: synced CSn=0 and WRn=0. ADDR to RD_WAIT: synced CSn=0 and RDn=0; reg_rd_req_o pulses in the entry cycle.
REQ-019 Synced RDn=0 and WRn=0 together SHALL be ignored: remain in ADDR and produce no strobe.
REQ-020 WRITE: capture synced AD every cycle. On the first cycle WRn or CSn is synced high, pulse reg_wr_en_o with the last captured data, then enter ADDR.
REQ-021 RD_WAIT: on reg_rd_ack_i, register reg_rd_data_i and enter RD_DRIVE. If CSn or RDn rises first, return to ADDR with no drive and no re-request.
REQ-022 RD_DRIVE: bus_dir_o=1 and bus_ad_io drives the registered data. Release (high-Z, dir=0) in the cycle after synced CSn or RDn goes high, then enter ADDR.
REQ-023 bus_ad_io SHALL be high-Z and bus_dir_o=0 in every state other than RD_DRIVE.
REQ-024 reg_rd_ack_i SHALL be ignored outside RD_WAIT. The user side SHALL ack within 4 cycles of the request to meet master sample timing.
REQ-025 reg_addr_o SHALL hold its value until the next ALE falling edge; a new ALE in ADDR overwrites it.

Reset
REQ-026 sys_rst SHALL force, asynchronously: state IDLE, bus high-Z, bus_dir_o=0, reg_addr_o=0, reg_wr_data_o=0, all strobes 0, synchronizers to 1 (idle bus level).
REQ-027 Reset during RD_DRIVE SHALL release the bus immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro SJA1000_SLV_TIMEOUT_EN defined: a counter clears on every state change and increments in WRITE, RD_WAIT and RD_DRIVE. On reaching TIMEOUT_CYCLES: go to IDLE, release the bus, pulse timeout_err_o, suppress any pending write.
REQ-029 Macro undefined: no counter is present and timeout_err_o is tied 0.

Structure
REQ-030 Shared package sja1000_slv_pkg SHALL hold the state encodings and the default SYNC_STAGES and TIMEOUT_CYCLES constants.
REQ-031 SHALL instantiate sub-module sja1000_sync_module: parameterized width and depth, reset to 1, instanced once over {ale,csn,rdn,wrn,ad}.

Verification
REQ-032 Write cycle: addr 0x12, data 0xA5, ALE falling, then CSn/WRn low for 8 cycles -> exactly one reg_wr_en_o pulse with reg_addr_o=0x12, reg_wr_data_o=0xA5.
REQ-033 Read cycle: addr 0x04, ack after 2 cycles with data 0x3C -> master samples 0x3C on AD; bus high-Z within SYNC_STAGES+1 cycles of RDn rising.
REQ-034 Read aborted before ack (CSn high after 1 cycle, no ack) -> no drive, bus_dir_o stays 0, exactly one reg_rd_req_o.
REQ-035 RDn and WRn low together -> no strobes, bus stays high-Z.
REQ-036 sys_rst asserted during RD_DRIVE -> bus high-Z and bus_dir_o=0 before the next clock edge; all outputs at reset values.
REQ-037 SJA1000_SLV_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, WRn held low indefinitely -> timeout_err_o pulses at cycle 16, no write strobe, state IDLE.
